// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the HI/LO multiply controller:
//   - DATA_W     : operand/register width (32 only; product is 2*DATA_W)
//   - OP_*       : ex_op encodings presented by the EX stage
//   - state_t    : controller FSM states
//   - is_mul_op  : true for MULT/MULTU
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd3;
    localparam logic [2:0] OP_MFLO  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // accepting HI/LO instructions
        ST_ISSUE = 2'd1,   // pulsing mul_start
        ST_BUSY  = 2'd2    // waiting for the multiplier to finish
    } state_t;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/mulu_fixup.sv
// -----------------------------------------------------------------------------
// mulu_fixup
// Turns the signed product of the shared multiplier into an unsigned product
// when is_u is set. Reinterpreting an operand with its top bit set as unsigned
// adds 2^DATA_W times the other operand, so the correction is one shifted add
// per negative operand, taken mod 2^(2*DATA_W).
// Ports:
//   a, b    in   DATA_W     operands that produced prod_s
//   prod_s  in   2*DATA_W   signed product
//   is_u    in   1          apply unsigned correction
//   prod    out  2*DATA_W   corrected product (combinational)
// -----------------------------------------------------------------------------
module mulu_fixup #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [2*DATA_W-1:0] prod_s,
    input  logic                is_u,
    output logic [2*DATA_W-1:0] prod
);

    logic [2*DATA_W-1:0] corr_a;
    logic [2*DATA_W-1:0] corr_b;

    assign corr_a = a[DATA_W-1] ? {b, {DATA_W{1'b0}}} : '0;
    assign corr_b = b[DATA_W-1] ? {a, {DATA_W{1'b0}}} : '0;

    assign prod = is_u ? (prod_s + corr_a + corr_b) : prod_s;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_hilo_ctrl
// EX-stage controller in front of a 32-cycle sequential multiplier. Launches
// MULT/MULTU, captures the (unsigned-corrected) product into HI/LO, serves
// MFHI/MFLO/MTHI/MTLO and stalls the pipeline while a HI/LO hazard is open.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   ex_op        EX-stage operation (muldiv_pkg OP_* encodings)
//   rs_val       rs operand (multiplier source, MTHI/MTLO data)
//   rt_val       rt operand (multiplicand source)
//   stall        hold EX and earlier stages this cycle
//   hilo_rdata   MFHI/MFLO result (combinational), 0 for other ops
//   mul_start    one-cycle launch pulse to the multiplier
//   mul_a/mul_b  latched operands for the multiplier
//   mul_ready    multiplier idle / result valid
//   mul_product  signed product from the multiplier
//   hi, lo       architectural HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_hilo_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_W-1:0]     ex_op,
    input  logic [DATA_W-1:0]   rs_val,
    input  logic [DATA_W-1:0]   rt_val,
    output logic                stall,
    output logic [DATA_W-1:0]   hilo_rdata,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic                mul_ready,
    input  logic [2*DATA_W-1:0] mul_product,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo
);

    import muldiv_pkg::*;

    state_t              state_q;
    state_t              state_d;
    logic                is_u;
    logic                accept;
    logic                capture;
    logic                hi_we;
    logic                lo_we;
    logic [2*DATA_W-1:0] prod_fixed;

    mulu_fixup #(.DATA_W(DATA_W)) u_fixup (
        .a      (mul_a),
        .b      (mul_b),
        .prod_s (mul_product),
        .is_u   (is_u),
        .prod   (prod_fixed)
    );

    // Next state, stall and write enables.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case leaves one unassigned (which would infer a latch).
        state_d = state_q;
        stall   = 1'b0;
        accept  = 1'b0;
        capture = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_mul_op(ex_op)) begin
                    // A multiplier left running across a reset must drain
                    // before a new MULT can be launched.
                    if (mul_ready) begin
                        accept  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    hi_we = (ex_op == OP_MTHI);
                    lo_we = (ex_op == OP_MTLO);
                end
            end
            ST_ISSUE: begin
                stall   = (ex_op != OP_NONE);
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // Capture edge accepts nothing: ops keep stalling until IDLE.
                stall = (ex_op != OP_NONE);
                if (mul_ready) begin
                    capture = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hilo_rdata = '0;
        if (ex_op == OP_MFHI) begin
            hilo_rdata = hi;
        end else if (ex_op == OP_MFLO) begin
            hilo_rdata = lo;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            is_u      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            state_q   <= state_d;
            mul_start <= accept;   // high exactly during ISSUE
            if (accept) begin
                mul_a <= rs_val;
                mul_b <= rt_val;
                is_u  <= (ex_op == OP_MULTU);
            end
            if (capture) begin
                hi <= prod_fixed[2*DATA_W-1:DATA_W];
                lo <= prod_fixed[DATA_W-1:0];
            end else begin
                if (hi_we) hi <= rs_val;
                if (lo_we) lo <= rs_val;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_hilo_ctrl
// Directed bench for muldiv_hilo_ctrl with a behavioural 32-cycle multiplier
// that, like the real one, has no reset. Inputs change on the falling edge;
// outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_muldiv_hilo_ctrl;

    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ex_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic [31:0] hilo_rdata;
    logic        mul_start;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_ready;
    logic [63:0] mul_product;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_hilo_ctrl #(.DATA_W(32), .OP_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_op       (ex_op),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .stall       (stall),
        .hilo_rdata  (hilo_rdata),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_ready   (mul_ready),
        .mul_product (mul_product),
        .hi          (hi),
        .lo          (lo)
    );

    // Sequential multiplier model: counter loads 32 on start, ready when 0.
    logic [5:0]  m_cnt  = 6'd0;
    logic [63:0] m_prod = 64'd0;

    always @(posedge clk) begin
        if (mul_start && m_cnt == 6'd0) begin
            m_cnt  <= 6'd32;
            m_prod <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        end else if (m_cnt != 6'd0) begin
            m_cnt <= m_cnt - 6'd1;
        end
    end

    assign mul_ready   = (m_cnt == 6'd0);
    assign mul_product = m_prod;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        ex_op  = op;
        rs_val = rs;
        rt_val = rt;
        #1;
    endtask

    // Hold a MULT/MULTU until it is accepted; the accepting edge is the next
    // rising edge after return. waits = number of stalled cycles seen.
    task automatic accept_mul(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b, output int waits);
        waits = 0;
        present(op, a, b);
        while (stall && waits < 200) begin
            waits++;
            present(op, a, b);
        end
        check({tag, " accept"}, 64'(stall), 64'd0);
    endtask

    // Present MFLO right after an accepted multiply: it must stall through
    // ISSUE and 33 BUSY cycles, then read the new LO.
    task automatic drain(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        present(OP_MFLO, 32'd0, 32'd0);
        check({tag, " mul_start"}, 64'(mul_start), 64'd1);
        check({tag, " mul_a"}, 64'(mul_a), 64'(a));
        check({tag, " mul_b"}, 64'(mul_b), 64'(b));
        while (stall && n < 100) begin
            n++;
            present(OP_MFLO, 32'd0, 32'd0);
        end
        check({tag, " stall cycles"}, 64'(n), 64'd34);
        check({tag, " mflo"}, 64'(hilo_rdata), 64'(exp_lo));
        check({tag, " lo"}, 64'(lo), 64'(exp_lo));
        check({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check({tag, " start low"}, 64'(mul_start), 64'd0);
        present(OP_MFHI, 32'd0, 32'd0);
        check({tag, " mfhi"}, 64'(hilo_rdata), 64'(exp_hi));
        check({tag, " mfhi stall"}, 64'(stall), 64'd0);
    endtask

    initial begin
        int w;
        rst_n  = 1'b0;
        ex_op  = OP_NONE;
        rs_val = '0;
        rt_val = '0;
        #1;
        check("rst hi", 64'(hi), 64'd0);
        check("rst lo", 64'(lo), 64'd0);
        check("rst mul_start", 64'(mul_start), 64'd0);
        check("rst mul_a", 64'(mul_a), 64'd0);
        check("rst mul_b", 64'(mul_b), 64'd0);
        check("rst stall", 64'(stall), 64'd0);
        check("rst rdata", 64'(hilo_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MTHI then MFHI, MTLO then MFLO, no stalls.
        present(OP_MTHI, 32'h1234_5678, 32'd0);
        check("mthi stall", 64'(stall), 64'd0);
        check("mthi rdata zero", 64'(hilo_rdata), 64'd0);
        present(OP_MFHI, 32'd0, 32'd0);
        check("mfhi stall", 64'(stall), 64'd0);
        check("mfhi rdata", 64'(hilo_rdata), 64'h1234_5678);
        present(OP_MTLO, 32'hCAFE_0001, 32'd0);
        present(OP_MFLO, 32'd0, 32'd0);
        check("mflo rdata", 64'(hilo_rdata), 64'hCAFE_0001);
        check("mt hi kept", 64'(hi), 64'h1234_5678);
        present(OP_NONE, 32'd0, 32'd0);
        check("none rdata", 64'(hilo_rdata), 64'd0);

        // Signed and unsigned products.
        accept_mul("mult 7x-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, w);
        drain("mult 7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        accept_mul("multu ffxff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        drain("multu ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        accept_mul("mult ffxff", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, w);
        drain("mult ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);

        accept_mul("mult 8x8", OP_MULT, 32'h8000_0000, 32'h8000_0000, w);
        drain("mult 8x8", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        accept_mul("multu 8x2", OP_MULTU, 32'h8000_0000, 32'd2, w);
        drain("multu 8x2", 32'h8000_0000, 32'd2, 32'h1, 32'h0);

        accept_mul("mult 8x2", OP_MULT, 32'h8000_0000, 32'd2, w);
        drain("mult 8x2", 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'h0);

        // Back-to-back: second MULT waits out the first, sees LO=15 written.
        accept_mul("b2b 3x5", OP_MULT, 32'd3, 32'd5, w);
        accept_mul("b2b 2x2", OP_MULT, 32'd2, 32'd2, w);
        check("b2b wait", 64'(w), 64'd34);
        check("b2b lo first", 64'(lo), 64'd15);
        check("b2b hi first", 64'(hi), 64'd0);
        drain("b2b 2x2", 32'd2, 32'd2, 32'd0, 32'd4);

        // Reset ten edges into a MULT; the multiplier keeps counting.
        accept_mul("rst mult", OP_MULT, 32'd7, 32'hFFFF_FFFD, w);
        for (int i = 0; i < 10; i++) begin
            present(OP_NONE, 32'd0, 32'd0);
            if (i == 0) check("busy none flows", 64'(stall), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst hi", 64'(hi), 64'd0);
        check("midrst lo", 64'(lo), 64'd0);
        check("midrst stall", 64'(stall), 64'd0);
        #2;
        rst_n = 1'b1;
        accept_mul("post rst", OP_MULT, 32'h8000_0000, 32'h8000_0000, w);
        check("post rst wait", 64'(w), 64'd22);
        drain("post rst", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

        present(OP_NONE, 32'd0, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
